// File: rtl/vga_plat_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_plat_timing_gen
// Purpose  : VGA timing generator and platform-band renderer for the Ice
//            Climbers display path. It runs on the board clock and
//            generates a pixel clock-enable internally, so there is no
//            divided clock net. It drives hsync/vsync and renders up to
//            NUM_PLAT horizontal colour bands over a background colour.
//
// Ports    : clk50mhz    - board clock (the only clock)
//            reset       - synchronous, active-high
//            plat_start  - band i top line    at [10i+9:10i]
//            plat_end    - band i bottom line at [10i+9:10i] (inclusive)
//            plat_color  - band i colour      at [RGB_W*i +: RGB_W]
//            bg_color    - background colour
//            hsync/vsync - sync outputs, polarity set by HSYNC_POL/VSYNC_POL
//            rgb         - pixel colour, 0 outside the active area
//            pixel_x/y   - coordinates of the pixel currently on rgb
//            video_on    - rgb is inside the active area
//            frame_start - one-clock pulse when the counters wrap to (0,0)
//
// Options  : VGA_PLAT_LATCH_EN - when defined, band and background inputs
//            are captured into shadow registers at each frame wrap, so
//            band changes never tear mid-frame.
//
// Revision : 1.0 - initial release
// ============================================================================
module vga_plat_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CLK_DIV   = 2,
    parameter int RGB_W     = 3,
    parameter int NUM_PLAT  = 4
) (
    input  logic                      clk50mhz,
    input  logic                      reset,
    input  logic [NUM_PLAT*10-1:0]    plat_start,
    input  logic [NUM_PLAT*10-1:0]    plat_end,
    input  logic [NUM_PLAT*RGB_W-1:0] plat_color,
    input  logic [RGB_W-1:0]          bg_color,
    output logic                      hsync,
    output logic                      vsync,
    output logic [RGB_W-1:0]          rgb,
    output logic [9:0]                pixel_x,
    output logic [9:0]                pixel_y,
    output logic                      video_on,
    output logic                      frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Keep the divider at least one bit wide so CLK_DIV=1 still elaborates;
    // the counter then sits at 0 and the enable is high every cycle.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       c_h_last    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       c_v_last    = 10'(V_TOTAL - 1);
    // Decode thresholds can reach 1024, so compare on 11 bits.
    localparam logic [10:0]      c_h_active  = 11'(H_ACTIVE);
    localparam logic [10:0]      c_hs_start  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      c_hs_end    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      c_v_active  = 11'(V_ACTIVE);
    localparam logic [10:0]      c_vs_start  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      c_vs_end    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             c_hs_on     = 1'(HSYNC_POL);
    localparam logic             c_vs_on     = 1'(VSYNC_POL);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;

    logic             w_pix_ce;
    logic [10:0]      w_h_ext;
    logic [10:0]      w_v_ext;
    logic             w_active;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_frame_wrap;
    logic [NUM_PLAT-1:0] w_hit;
    logic [RGB_W-1:0] w_band_color;
    logic [RGB_W-1:0] w_rgb_next;

    // Sources used for rendering: live inputs or frame-latched shadows.
    logic [NUM_PLAT*10-1:0]    w_src_start;
    logic [NUM_PLAT*10-1:0]    w_src_end;
    logic [NUM_PLAT*RGB_W-1:0] w_src_color;
    logic [RGB_W-1:0]          w_src_bg;

    assign w_pix_ce     = (r_div_cnt == c_div_last);
    assign w_h_ext      = {1'b0, r_h_cnt};
    assign w_v_ext      = {1'b0, r_v_cnt};
    assign w_active     = (w_h_ext < c_h_active) && (w_v_ext < c_v_active);
    assign w_hs_act     = (w_h_ext >= c_hs_start) && (w_h_ext < c_hs_end);
    assign w_vs_act     = (w_v_ext >= c_vs_start) && (w_v_ext < c_vs_end);
    assign w_frame_wrap = (r_h_cnt == c_h_last) && (r_v_cnt == c_v_last);

`ifdef VGA_PLAT_LATCH_EN
    logic [NUM_PLAT*10-1:0]    r_sh_start;
    logic [NUM_PLAT*10-1:0]    r_sh_end;
    logic [NUM_PLAT*RGB_W-1:0] r_sh_color;
    logic [RGB_W-1:0]          r_sh_bg;

    // Shadows load on the same enable that raises frame_start; the pixel
    // rendered on that edge still uses the old set (it is blanking anyway).
    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            r_sh_start <= '1;   // start=1023, end=0: every band disabled
            r_sh_end   <= '0;
            r_sh_color <= '0;
            r_sh_bg    <= '0;
        end else if (w_pix_ce && w_frame_wrap) begin
            r_sh_start <= plat_start;
            r_sh_end   <= plat_end;
            r_sh_color <= plat_color;
            r_sh_bg    <= bg_color;
        end
    end

    assign w_src_start = r_sh_start;
    assign w_src_end   = r_sh_end;
    assign w_src_color = r_sh_color;
    assign w_src_bg    = r_sh_bg;
`else
    assign w_src_start = plat_start;
    assign w_src_end   = plat_end;
    assign w_src_color = plat_color;
    assign w_src_bg    = bg_color;
`endif

    // Band hit depends only on the line; start > end can never satisfy both.
    generate
        for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_band
            assign w_hit[gi] = (r_v_cnt >= w_src_start[gi*10 +: 10]) &&
                               (r_v_cnt <= w_src_end[gi*10 +: 10]);
        end
    endgenerate

    // Walk from the highest index down so the lowest hitting band wins.
    always_comb begin
        w_band_color = w_src_bg;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_band_color = w_src_color[i*RGB_W +: RGB_W];
            end
        end
    end

    assign w_rgb_next = w_active ? w_band_color : '0;

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            r_div_cnt   <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            hsync       <= ~c_hs_on;
            vsync       <= ~c_vs_on;
            rgb         <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_div_cnt   <= w_pix_ce ? '0 : r_div_cnt + 1'b1;
            // Cleared every clock so the pulse is one board cycle wide even
            // when the pixel rate is slower than the clock.
            frame_start <= 1'b0;
            if (w_pix_ce) begin
                // Outputs take the decode of the pre-advance counters.
                hsync       <= w_hs_act ? c_hs_on : ~c_hs_on;
                vsync       <= w_vs_act ? c_vs_on : ~c_vs_on;
                rgb         <= w_rgb_next;
                pixel_x     <= r_h_cnt;
                pixel_y     <= r_v_cnt;
                video_on    <= w_active;
                frame_start <= w_frame_wrap;
                if (r_h_cnt == c_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_plat_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plat_timing_gen
// Purpose  : Self-checking bench for vga_plat_timing_gen. Uses a reduced
//            raster (100 x 60 totals, CLK_DIV=2) so several frames fit in a
//            short run. A pixel-index model derives every output from the
//            number of clocks since reset release; literal pins anchor it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plat_timing_gen;

    localparam int H_ACTIVE = 64, H_FP = 8, H_SYNC = 12, H_BP = 16;
    localparam int V_ACTIVE = 48, V_FP = 4, V_SYNC = 2, V_BP = 6;
    localparam int CLK_DIV  = 2, RGB_W = 3, NUM_PLAT = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_PIX = H_TOTAL * V_TOTAL;
    localparam int FRAME_CYC = FRAME_PIX * CLK_DIV;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_PLAT*10-1:0]    plat_start;
    logic [NUM_PLAT*10-1:0]    plat_end;
    logic [NUM_PLAT*RGB_W-1:0] plat_color;
    logic [RGB_W-1:0]          bg_color;
    logic                      hsync, vsync, video_on, frame_start;
    logic [RGB_W-1:0]          rgb;
    logic [9:0]                pixel_x, pixel_y;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vga_plat_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(CLK_DIV),
        .RGB_W(RGB_W), .NUM_PLAT(NUM_PLAT)
    ) dut (
        .clk50mhz   (clk),
        .reset      (reset),
        .plat_start (plat_start),
        .plat_end   (plat_end),
        .plat_color (plat_color),
        .bg_color   (bg_color),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_start(frame_start)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Spec-level colour rule: first band (lowest index) whose inclusive
    // line range contains v, else background; black outside the active area.
    function automatic logic [RGB_W-1:0] model_rgb(
        input int h, input int v,
        input logic [NUM_PLAT*10-1:0] st, input logic [NUM_PLAT*10-1:0] en,
        input logic [NUM_PLAT*RGB_W-1:0] col, input logic [RGB_W-1:0] bg);
        if (h >= H_ACTIVE || v >= V_ACTIVE) return '0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (v >= int'(st[i*10 +: 10]) && v <= int'(en[i*10 +: 10]))
                return col[i*RGB_W +: RGB_W];
        end
        return bg;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    initial begin : compare
        int n, k, p, h, v, fidx;
        bit fresh;
        logic e_hs, e_vs, e_von, e_fs;
        logic [RGB_W-1:0] e_rgb;
        int e_x, e_y;
        logic [NUM_PLAT*10-1:0]    sh_st, sh_en;
        logic [NUM_PLAT*RGB_W-1:0] sh_col;
        logic [RGB_W-1:0]          sh_bg;
        n = 0; h = 0; v = 0; fidx = 0;
        e_hs = 1; e_vs = 1; e_von = 0; e_fs = 0; e_rgb = '0; e_x = 0; e_y = 0;
        sh_st = '1; sh_en = '0; sh_col = '0; sh_bg = '0;
        forever begin
            @(posedge clk);
            fresh = 0;
            if (reset) begin
                n = 0;
                e_hs = 1; e_vs = 1; e_von = 0; e_fs = 0; e_rgb = '0; e_x = 0; e_y = 0;
                sh_st = '1; sh_en = '0; sh_col = '0; sh_bg = '0;
            end else begin
                n++;
                e_fs = 0;
                if (n % CLK_DIV == 0) begin
                    k = n / CLK_DIV - 1;
                    p = k % FRAME_PIX;
                    fidx = k / FRAME_PIX;
                    h = p % H_TOTAL;
                    v = p / H_TOTAL;
                    fresh = 1;
                    e_x = h; e_y = v;
                    e_von = (h < H_ACTIVE) && (v < V_ACTIVE);
                    e_hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
                    e_vs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
                    e_fs = (p == FRAME_PIX - 1);
`ifdef VGA_PLAT_LATCH_EN
                    e_rgb = model_rgb(h, v, sh_st, sh_en, sh_col, sh_bg);
                    if (p == FRAME_PIX - 1) begin
                        sh_st = plat_start; sh_en = plat_end;
                        sh_col = plat_color; sh_bg = bg_color;
                    end
`else
                    e_rgb = model_rgb(h, v, plat_start, plat_end, plat_color, bg_color);
`endif
                end
            end
            #1;
            chk("hsync",       int'(hsync),       int'(e_hs));
            chk("vsync",       int'(vsync),       int'(e_vs));
            chk("rgb",         int'(rgb),         int'(e_rgb));
            chk("pixel_x",     int'(pixel_x),     e_x);
            chk("pixel_y",     int'(pixel_y),     e_y);
            chk("video_on",    int'(video_on),    int'(e_von));
            chk("frame_start", int'(frame_start), int'(e_fs));

            // Hand-computed anchors for the model.
            if (reset) begin
                chk("rst_hsync", int'(hsync), 1);
                chk("rst_rgb",   int'(rgb),   0);
            end
            if (!reset && n == 1) chk("pre_ce_video_on", int'(video_on), 0);
            if (fresh && n == CLK_DIV) begin
                chk("first_x", int'(pixel_x), 0);
                chk("first_y", int'(pixel_y), 0);
                chk("first_von", int'(video_on), 1);
            end
            if (fresh && fidx == 1) begin
                if (h == 5  && v == 11) chk("band0_y11",   int'(rgb), 3'b100);
                if (h == 5  && v == 13) chk("overlap_y13", int'(rgb), 3'b100);
                if (h == 5  && v == 16) chk("band1_y16",   int'(rgb), 3'b010);
                if (h == 5  && v == 25) chk("disabled_y25", int'(rgb), 3'b001);
                if (h == 5  && v == 42) chk("band3_y42",   int'(rgb), 3'b011);
                if (h == 70 && v == 11) chk("blank_x70",   int'(rgb), 0);
                if (h == 71 && v == 0)  chk("hs_x71", int'(hsync), 1);
                if (h == 72 && v == 0)  chk("hs_x72", int'(hsync), 0);
                if (h == 83 && v == 0)  chk("hs_x83", int'(hsync), 0);
                if (h == 84 && v == 0)  chk("hs_x84", int'(hsync), 1);
                if (h == 0  && v == 51) chk("vs_y51", int'(vsync), 1);
                if (h == 0  && v == 52) chk("vs_y52", int'(vsync), 0);
                if (h == 0  && v == 53) chk("vs_y53", int'(vsync), 0);
                if (h == 0  && v == 54) chk("vs_y54", int'(vsync), 1);
            end
            if (fresh && fidx == 2 && h == 5 && v == 11)
`ifdef VGA_PLAT_LATCH_EN
                chk("latched_old_color", int'(rgb), 3'b100);
`else
                chk("live_new_color", int'(rgb), 3'b110);
`endif
            if (fresh && fidx == 3 && h == 5 && v == 11)
                chk("next_frame_color", int'(rgb), 3'b110);
        end
    end

    // ---------------- pulse spacing / sync width ----------------
    initial begin : pulses
        int cyc, last_fs, hs_run;
        logic prev_fs;
        cyc = 0; last_fs = -1; hs_run = 0; prev_fs = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                last_fs = -1; hs_run = 0; prev_fs = 0;
            end else begin
                if (frame_start) begin
                    chk("fs_width", int'(prev_fs), 0);
                    if (last_fs >= 0) chk("fs_spacing", cyc - last_fs, FRAME_CYC);
                    last_fs = cyc;
                end
                prev_fs = frame_start;
                if (!hsync) hs_run++;
                else begin
                    if (hs_run > 0) chk("hs_width_cycles", hs_run, H_SYNC * CLK_DIV);
                    hs_run = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        reset      = 1'b1;
        plat_start = {10'd40, 10'd30, 10'd12, 10'd10};
        plat_end   = {10'd44, 10'd20, 10'd18, 10'd14};
        plat_color = {3'b011, 3'b111, 3'b010, 3'b100};
        bg_color   = 3'b001;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        // Frame 2, line 5 is pixel index 2*FRAME_PIX + 5*H_TOTAL.
        repeat ((2 * FRAME_PIX + 5 * H_TOTAL + 1) * CLK_DIV) @(posedge clk);
        @(negedge clk) plat_color[2:0] = 3'b110;
        // Into frame 3, then a mid-frame reset.
        repeat (15000) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
